rle_codec: RTL and testbench

//   Parametrised run-length encoder/decoder with valid/ready streaming on both sides.

---
 rtl/rle_codec.sv | 202 ++++++++++++++++++++
 tb/tb_rle_codec.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_codec.sv
// rle_codec: run-length encoder/decoder with valid/ready streaming on both sides.
//
// Encode (dir_i=1) folds runs of identical DATA_W words into {count,data} tokens.
// Decode (dir_i=0) expands {count,data} tokens back into a word stream.
//
// Ports:
//   clock_i      system clock, rising edge
//   sysres_ni    asynchronous reset, active-low
//   dir_i        1=encode, 0=decode; only looked at while idle
//   in_valid_i   input word/token valid
//   in_ready_o   block accepts input this cycle
//   in_data_i    input word (enc) / token data (dec)
//   in_count_i   token count (dec only)
//   in_last_i    final word/token of frame
//   out_valid_o  output valid
//   out_ready_i  downstream accepts output
//   out_data_o   token data (enc) / expanded word (dec)
//   out_count_o  run length (enc) / remaining words incl. this one (dec)
//   out_last_o   final token/word of frame
module rle_codec #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clock_i,
    input  logic              sysres_ni,
    input  logic              dir_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CNT_W-1:0]  in_count_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  out_count_o,
    output logic              out_last_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;  // encode: accumulating a run
    localparam logic [1:0] StFlush  = 2'd2;  // encode: trailing single word pending
    localparam logic [1:0] StExpand = 2'd3;  // decode: emitting a token's words

    localparam logic [CNT_W-1:0] MaxCnt = '1;
    localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

    // The mode is implied by the state (RUN/FLUSH encode, EXPAND decode), so dir_i
    // changes outside IDLE have no effect without a separate latched copy.
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] cur_q, cur_d;    // run word (enc) / token data (dec)
    logic [CNT_W-1:0]  cnt_q, cnt_d;    // run length (enc) / remaining words (dec)
    logic              last_q, last_d;  // decode: token closes the frame

    // Single output register
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] od_q, od_d;
    logic [CNT_W-1:0]  oc_q, oc_d;
    logic              ol_q, ol_d;

    logic oreg_free;
    logic in_fire;
    logic run_match;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        ov_d       = ov_q;
        od_d       = od_q;
        oc_d       = oc_q;
        ol_d       = ol_q;
        oreg_free  = !ov_q || out_ready_i;
        in_ready_o = 1'b0;
        run_match  = (in_data_i == cur_q) && (cnt_q != MaxCnt);

        if (ov_q && out_ready_i) begin
            ov_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Gated on oreg_free so a still-pending final token is never overwritten.
                in_ready_o = oreg_free;
            end
            StRun: begin
                in_ready_o = oreg_free;
            end
            default: begin
                in_ready_o = 1'b0;
            end
        endcase

        in_fire = in_valid_i && in_ready_o;

        unique case (state_q)
            StIdle: begin
                if (in_fire) begin
                    if (dir_i) begin
                        if (in_last_i) begin
                            ov_d = 1'b1;
                            od_d = in_data_i;
                            oc_d = OneCnt;
                            ol_d = 1'b1;
                        end else begin
                            cur_d   = in_data_i;
                            cnt_d   = OneCnt;
                            state_d = StRun;
                        end
                    end else if (in_count_i != '0) begin
                        // Zero-count tokens are consumed silently, even with in_last.
                        cur_d   = in_data_i;
                        cnt_d   = in_count_i;
                        last_d  = in_last_i;
                        ov_d    = 1'b1;
                        od_d    = in_data_i;
                        oc_d    = in_count_i;
                        ol_d    = in_last_i && (in_count_i == OneCnt);
                        state_d = StExpand;
                    end
                end
            end
            StRun: begin
                if (in_fire) begin
                    if (run_match && !in_last_i) begin
                        cnt_d = cnt_q + OneCnt;
                    end else if (run_match) begin
                        ov_d    = 1'b1;
                        od_d    = cur_q;
                        oc_d    = cnt_q + OneCnt;
                        ol_d    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        // Run broken (new word or count saturated): close it out.
                        ov_d  = 1'b1;
                        od_d  = cur_q;
                        oc_d  = cnt_q;
                        ol_d  = 1'b0;
                        cur_d = in_data_i;
                        cnt_d = OneCnt;
                        if (in_last_i) begin
                            state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: begin
                if (oreg_free) begin
                    ov_d    = 1'b1;
                    od_d    = cur_q;
                    oc_d    = OneCnt;
                    ol_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            StExpand: begin
                if (ov_q && out_ready_i) begin
                    if (cnt_q == OneCnt) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - OneCnt;
                        ov_d  = 1'b1;
                        od_d  = cur_q;
                        oc_d  = cnt_q - OneCnt;
                        ol_d  = last_q && ((cnt_q - OneCnt) == OneCnt);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge sysres_ni) begin
        if (!sysres_ni) begin
            state_q <= StIdle;
            cur_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            oc_q    <= '0;
            ol_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            oc_q    <= oc_d;
            ol_q    <= ol_d;
        end
    end

    assign out_valid_o = ov_q;
    assign out_data_o  = od_q;
    assign out_count_o = oc_q;
    assign out_last_o  = ol_q;

endmodule

// File: tb/tb_rle_codec.sv
// tb_rle_codec: directed bench for rle_codec. Two instances share the input bus:
// u_dut_a (CNT_W=8) and u_dut_b (CNT_W=2); sel picks which one sees in_valid.
module tb_rle_codec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dir = 1'b1;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [7:0]  in_count = '0;
    logic        in_last = 1'b0;
    logic        rdy = 1'b1;
    logic        tog = 1'b0;
    logic        ph = 1'b0;
    logic        out_ready;
    logic        in_ready;

    logic        ir_a, ov_a, ol_a;
    logic [31:0] od_a;
    logic [7:0]  oc_a;
    logic        ir_b, ov_b, ol_b;
    logic [31:0] od_b;
    logic [1:0]  oc_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [40:0] q_a[$];
    logic [40:0] q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) ph <= ~ph;

    assign out_ready = tog ? ph : rdy;
    assign in_ready  = sel ? ir_b : ir_a;

    rle_codec #(.DATA_W(32), .CNT_W(8)) u_dut_a (
        .clock_i    (clk),
        .sysres_ni  (rst_n),
        .dir_i      (dir),
        .in_valid_i (in_valid && !sel),
        .in_ready_o (ir_a),
        .in_data_i  (in_data),
        .in_count_i (in_count),
        .in_last_i  (in_last),
        .out_valid_o(ov_a),
        .out_ready_i(out_ready),
        .out_data_o (od_a),
        .out_count_o(oc_a),
        .out_last_o (ol_a)
    );

    rle_codec #(.DATA_W(32), .CNT_W(2)) u_dut_b (
        .clock_i    (clk),
        .sysres_ni  (rst_n),
        .dir_i      (dir),
        .in_valid_i (in_valid && sel),
        .in_ready_o (ir_b),
        .in_data_i  (in_data),
        .in_count_i (in_count[1:0]),
        .in_last_i  (in_last),
        .out_valid_o(ov_b),
        .out_ready_i(out_ready),
        .out_data_o (od_b),
        .out_count_o(oc_b),
        .out_last_o (ol_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, inputs only move just after rising edges.
    logic        stall_prev = 1'b0;
    logic [40:0] snap_prev = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_stable", {23'd0, ol_a, oc_a, od_a}, {23'd0, snap_prev});
            end
            if (ov_a && !out_ready) begin
                check_eq("in_ready_stall", {63'd0, ir_a}, 64'd0);
            end
            stall_prev = ov_a && !out_ready;
            snap_prev  = {ol_a, oc_a, od_a};
            if (ov_a && out_ready) q_a.push_back({ol_a, oc_a, od_a});
            if (ov_b && out_ready) q_b.push_back({ol_b, 6'd0, oc_b, od_b});
        end
    end

    task automatic send(input logic [31:0] d, input logic [7:0] c, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_count = c;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_eq("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [31:0] d, input logic last_on_final);
        for (int i = 0; i < n; i++) begin
            send(d, 8'd0, last_on_final && (i == n - 1));
        end
    endtask

    task automatic expect_tok(input string tag, input bit which, input logic l,
                              input logic [7:0] c, input logic [31:0] d);
        logic [40:0] tok;
        tok = '1;
        if (!which && q_a.size() > 0) tok = q_a.pop_front();
        if (which && q_b.size() > 0) tok = q_b.pop_front();
        check_eq(tag, {23'd0, tok}, {23'd0, l, c, d});
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        #3;
        check_eq("rst_valid", {63'd0, ov_a}, 64'd0);
        check_eq("rst_data", {32'd0, od_a}, 64'd0);
        check_eq("rst_count", {56'd0, oc_a}, 64'd0);
        check_eq("rst_last", {63'd0, ol_a}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: encode, free-flowing output
        dir = 1'b1;
        send_n(5, 32'hDEADBEEF, 1'b0);
        send_n(3, 32'hFFFFFFFF, 1'b0);
        send_n(4, 32'h00000000, 1'b0);
        send(32'hA0A0A0A0, 8'd0, 1'b1);
        settle();
        check_eq("t1_ntok", 64'(q_a.size()), 64'd4);
        expect_tok("t1_tok0", 1'b0, 1'b0, 8'd5, 32'hDEADBEEF);
        expect_tok("t1_tok1", 1'b0, 1'b0, 8'd3, 32'hFFFFFFFF);
        expect_tok("t1_tok2", 1'b0, 1'b0, 8'd4, 32'h00000000);
        expect_tok("t1_tok3", 1'b0, 1'b1, 8'd1, 32'hA0A0A0A0);

        // 2: encode with CNT_W=2, saturating runs and the flush path
        sel = 1'b1;
        send_n(7, 32'h12345678, 1'b1);
        settle();
        sel = 1'b0;
        check_eq("t2_ntok", 64'(q_b.size()), 64'd3);
        expect_tok("t2_tok0", 1'b1, 1'b0, 8'd3, 32'h12345678);
        expect_tok("t2_tok1", 1'b1, 1'b0, 8'd3, 32'h12345678);
        expect_tok("t2_tok2", 1'b1, 1'b1, 8'd1, 32'h12345678);

        // 3: encode under toggling backpressure
        tog = 1'b1;
        send_n(5, 32'hDEADBEEF, 1'b0);
        send_n(3, 32'hFFFFFFFF, 1'b0);
        send_n(4, 32'h00000000, 1'b0);
        send(32'hA0A0A0A0, 8'd0, 1'b1);
        settle();
        tog = 1'b0;
        settle();
        check_eq("t3_ntok", 64'(q_a.size()), 64'd4);
        expect_tok("t3_tok0", 1'b0, 1'b0, 8'd5, 32'hDEADBEEF);
        expect_tok("t3_tok1", 1'b0, 1'b0, 8'd3, 32'hFFFFFFFF);
        expect_tok("t3_tok2", 1'b0, 1'b0, 8'd4, 32'h00000000);
        expect_tok("t3_tok3", 1'b0, 1'b1, 8'd1, 32'hA0A0A0A0);

        // 4: decode, including a zero-count token that must vanish
        dir = 1'b0;
        send(32'hDEADBEEF, 8'd3, 1'b0);
        send(32'hFFFFFFFF, 8'd0, 1'b0);
        send(32'hA0A0A0A0, 8'd2, 1'b1);
        settle();
        check_eq("t4_nword", 64'(q_a.size()), 64'd5);
        expect_tok("t4_w0", 1'b0, 1'b0, 8'd3, 32'hDEADBEEF);
        expect_tok("t4_w1", 1'b0, 1'b0, 8'd2, 32'hDEADBEEF);
        expect_tok("t4_w2", 1'b0, 1'b0, 8'd1, 32'hDEADBEEF);
        expect_tok("t4_w3", 1'b0, 1'b0, 8'd2, 32'hA0A0A0A0);
        expect_tok("t4_w4", 1'b0, 1'b1, 8'd1, 32'hA0A0A0A0);

        // 5: reset mid-run with a token parked in the output register
        dir = 1'b1;
        rdy = 1'b0;
        send_n(3, 32'hDEADBEEF, 1'b0);
        send(32'h11111111, 8'd0, 1'b0);
        check_eq("t5_parked", {63'd0, ov_a}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", {63'd0, ov_a}, 64'd0);
        check_eq("t5_rst_data", {32'd0, od_a}, 64'd0);
        check_eq("t5_rst_count", {56'd0, oc_a}, 64'd0);
        check_eq("t5_rst_last", {63'd0, ol_a}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t5_no_tok", 64'(q_a.size()), 64'd0);
        send_n(2, 32'hFFFFFFFF, 1'b1);
        settle();
        check_eq("t5_ntok", 64'(q_a.size()), 64'd1);
        expect_tok("t5_tok0", 1'b0, 1'b1, 8'd2, 32'hFFFFFFFF);

        // 6: dir flipped during expansion is ignored until back in idle
        dir = 1'b0;
        send(32'h55555555, 8'd3, 1'b1);
        dir = 1'b1;
        send(32'h77777777, 8'd0, 1'b1);
        settle();
        check_eq("t6_ntok", 64'(q_a.size()), 64'd4);
        expect_tok("t6_w0", 1'b0, 1'b0, 8'd3, 32'h55555555);
        expect_tok("t6_w1", 1'b0, 1'b0, 8'd2, 32'h55555555);
        expect_tok("t6_w2", 1'b0, 1'b1, 8'd1, 32'h55555555);
        expect_tok("t6_enc", 1'b0, 1'b1, 8'd1, 32'h77777777);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
